// File: rtl/pipe_pkg.sv
// Shared pipeline constants: opcodes, immediate-kind encodings and the bubble instruction word.
package pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM16    = 2'd1,
    IMM26    = 2'd2
  } imm_kind_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode-to-extender-control map; shared with the reference model.
module imm_decode
  import pipe_pkg::*;
(
  input  logic [5:0] op,
  input  logic       valid,
  output logic [1:0] kind,
  output logic       ext16_sel,
  output logic       ext26_sel,
  output logic       byte_sel
);

  imm_kind_e kind_e;

  always_comb begin
    kind_e    = IMM_NONE;
    ext16_sel = 1'b0;
    ext26_sel = 1'b0;
    byte_sel  = 1'b0;
    if (valid) begin
      case (op)
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_BEQ, OP_BNE,
        OP_LB, OP_LBU, OP_LW, OP_SB, OP_SW: begin
          kind_e    = IMM16;
          ext16_sel = 1'b1;
          byte_sel  = (op == OP_LB);
        end
        OP_ANDI, OP_ORI, OP_XORI, OP_LUI: kind_e = IMM16;
        // jump targets are always zero-extended, so ext26_sel stays 0
        OP_J, OP_JAL: kind_e = IMM26;
        default: kind_e = IMM_NONE;
      endcase
    end
  end

  assign kind = kind_e;

endmodule

// File: rtl/ifid_imm_stage.sv
// IF/ID pipeline register with immediate-field decode for the downstream extenders.
// Optional stall_cycles counter enabled by defining IFID_STALL_CNT_EN.
module ifid_imm_stage #(
  parameter int              DW       = 32,
  parameter logic [DW-1:0]   NOP_WORD = pipe_pkg::NOP_WORD
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_valid,
  input  logic [DW-1:0] if_instr,
  input  logic [DW-1:0] if_pc,
  input  logic          stall,
  input  logic          flush,
  output logic          if_ready,
  output logic          id_valid,
  output logic [DW-1:0] id_instr,
  output logic [DW-1:0] id_pc,
  output logic [15:0]   id_imm16,
  output logic [25:0]   id_imm26,
  output logic          id_ext16_sel,
  output logic          id_ext26_sel,
  output logic          id_byte_sel,
`ifdef IFID_STALL_CNT_EN
  output logic [31:0]   stall_cycles,
`endif
  output logic [1:0]    id_imm_kind
);

  import pipe_pkg::*;

  logic          valid_q, valid_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [DW-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = NOP_WORD;
      pc_d    = '0;
    end else if (!stall) begin
      valid_d = if_valid;
      instr_d = if_valid ? if_instr : NOP_WORD;
      pc_d    = if_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= NOP_WORD;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign if_ready = ~stall | flush;
  assign id_valid = valid_q;
  assign id_instr = instr_q;
  assign id_pc    = pc_q;

  // raw slices are passed unmasked except when the slot is a bubble
  assign id_imm16 = valid_q ? instr_q[15:0] : 16'h0;
  assign id_imm26 = valid_q ? instr_q[25:0] : 26'h0;

  imm_decode u_imm_decode (
    .op        (instr_q[31:26]),
    .valid     (valid_q),
    .kind      (id_imm_kind),
    .ext16_sel (id_ext16_sel),
    .ext26_sel (id_ext26_sel),
    .byte_sel  (id_byte_sel)
  );

`ifdef IFID_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !flush && valid_q && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifid_imm_stage.sv
// Scoreboard bench for ifid_imm_stage: stimulus queues expected ID state, monitor checks after each edge.
module tb_ifid_imm_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = '0;
  logic [31:0] if_pc = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        if_ready, id_valid, id_ext16_sel, id_ext26_sel, id_byte_sel;
  logic [31:0] id_instr, id_pc;
  logic [15:0] id_imm16;
  logic [25:0] id_imm26;
  logic [1:0]  id_imm_kind;
`ifdef IFID_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  ifid_imm_stage dut (
    .clk          (clk),
    .reset        (reset),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .stall        (stall),
    .flush        (flush),
    .if_ready     (if_ready),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_imm16     (id_imm16),
    .id_imm26     (id_imm26),
    .id_ext16_sel (id_ext16_sel),
    .id_ext26_sel (id_ext26_sel),
    .id_byte_sel  (id_byte_sel),
`ifdef IFID_STALL_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .id_imm_kind  (id_imm_kind)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  kind;
    logic        e16;
    logic        b;
    logic        rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic chk_all(input exp_t e);
    logic [31:0] ei;
    ei = e.instr;
    chk("id_valid", {31'b0, id_valid}, {31'b0, e.v});
    chk("id_instr", id_instr, e.instr);
    chk("id_pc", id_pc, e.pc);
    chk("id_imm16", {16'b0, id_imm16}, e.v ? {16'b0, ei[15:0]} : 32'h0);
    chk("id_imm26", {6'b0, id_imm26}, e.v ? {6'b0, ei[25:0]} : 32'h0);
    chk("id_imm_kind", {30'b0, id_imm_kind}, {30'b0, e.kind});
    chk("id_ext16_sel", {31'b0, id_ext16_sel}, {31'b0, e.e16});
    chk("id_ext26_sel", {31'b0, id_ext26_sel}, 32'h0);
    chk("id_byte_sel", {31'b0, id_byte_sel}, {31'b0, e.b});
    chk("if_ready", {31'b0, if_ready}, {31'b0, e.rdy});
  endtask

  // monitor: one expected entry per clock edge, checked just after the edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) chk_all(exp_q.pop_front());
    end
  end

  task automatic apply(input logic iv, input logic [31:0] ii, input logic [31:0] ip,
                       input logic st, input logic fl,
                       input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                       input logic [1:0] ek, input logic e16, input logic eb);
    exp_t e;
    @(negedge clk);
    if_valid = iv; if_instr = ii; if_pc = ip; stall = st; flush = fl;
    e.v = ev; e.instr = ei; e.pc = ep; e.kind = ek; e.e16 = e16; e.b = eb;
    e.rdy = ~st | fl;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t r;
    #2;
    r.v = 0; r.instr = 0; r.pc = 0; r.kind = 0; r.e16 = 0; r.b = 0; r.rdy = 1;
    chk_all(r);
    @(negedge clk);
    reset = 1'b0;

    //     iv instr         pc     st fl  ev instr         pc     k  e16 b
    apply(1, 32'h2008FFFC, 32'h04, 0, 0,  1, 32'h2008FFFC, 32'h04, 1, 1, 0); // addi
    apply(1, 32'h35088000, 32'h08, 0, 0,  1, 32'h35088000, 32'h08, 1, 0, 0); // ori
    apply(1, 32'h08100004, 32'h0C, 0, 0,  1, 32'h08100004, 32'h0C, 2, 0, 0); // j
    apply(1, 32'h8C000001, 32'h10, 1, 0,  1, 32'h08100004, 32'h0C, 2, 0, 0); // stall x3
    apply(1, 32'h2001AAAA, 32'h50, 1, 0,  1, 32'h08100004, 32'h0C, 2, 0, 0);
    apply(1, 32'h3C015555, 32'h60, 1, 0,  1, 32'h08100004, 32'h0C, 2, 0, 0);
    apply(1, 32'h8C000001, 32'h10, 0, 0,  1, 32'h8C000001, 32'h10, 1, 1, 0); // lw
    apply(1, 32'h20010001, 32'h14, 1, 1,  0, 32'h00000000, 32'h00, 0, 0, 0); // stall+flush
    apply(1, 32'h81090003, 32'h18, 0, 0,  1, 32'h81090003, 32'h18, 1, 1, 1); // lb
    apply(1, 32'h91090003, 32'h1C, 0, 0,  1, 32'h91090003, 32'h1C, 1, 1, 0); // lbu
    apply(0, 32'h2008FFFC, 32'h20, 0, 0,  0, 32'h00000000, 32'h20, 0, 0, 0); // bubble
    apply(1, 32'h00221820, 32'h24, 0, 0,  1, 32'h00221820, 32'h24, 0, 0, 0); // R-type
    apply(1, 32'hFC001234, 32'h28, 0, 0,  1, 32'hFC001234, 32'h28, 0, 0, 0); // unlisted
    apply(1, 32'h10220005, 32'h2C, 0, 0,  1, 32'h10220005, 32'h2C, 1, 1, 0); // beq
    apply(1, 32'h3C01ABCD, 32'h30, 0, 0,  1, 32'h3C01ABCD, 32'h30, 1, 0, 0); // lui
    apply(1, 32'h0C000010, 32'h34, 0, 0,  1, 32'h0C000010, 32'h34, 2, 0, 0); // jal

    // asynchronous reset mid-cycle while holding the jal
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    r.v = 0; r.instr = 0; r.pc = 0; r.kind = 0; r.e16 = 0; r.b = 0; r.rdy = 1;
    chk_all(r);
    @(negedge clk);
    reset = 1'b0;

    apply(1, 32'h2008FFFC, 32'h40, 0, 0,  1, 32'h2008FFFC, 32'h40, 1, 1, 0);
    repeat (5)
      apply(1, 32'h35088000, 32'h44, 1, 0,  1, 32'h2008FFFC, 32'h40, 1, 1, 0);
    @(negedge clk);
`ifdef IFID_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, 32'd5);
    reset = 1'b1;
    #1;
    chk("stall_cycles_rst", stall_cycles, 32'd0);
    @(negedge clk);
    reset = 1'b0;
`endif
    stall = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish before 20000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ifid_imm_stage.md
Name: ifid_imm_stage

Overview:
- IF/ID pipeline register plus immediate-field decode.
- Captures the fetched instruction and PC each cycle, holds them on stall, and squashes them to a bubble on flush.
- From the held instruction it drives the raw immediate fields and extension-select controls consumed by the 16-, 8- and 26-bit extender blocks in ID/MEM.
- Sits directly upstream of the extenders, between fetch and decode/register-read.

Parameters:
- DW, 32, instruction/PC width.
- NOP_WORD, 32'h0000_0000, instruction value inserted on bubble/flush/reset.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_valid  in  1  fetch stage presents a valid instruction
- if_instr  in  DW  fetched instruction
- if_pc  in  DW  PC+4 of fetched instruction
- stall  in  1  hazard unit: hold IF/ID contents
- flush  in  1  branch/jump resolved taken: squash IF/ID
- if_ready  out  1  upstream may advance PC (combinational, = ~stall | flush)
- id_valid  out  1  register holds a real instruction
- id_instr  out  DW  held instruction
- id_pc  out  DW  held PC+4
- id_imm16  out  16  id_instr[15:0], to 16-bit extender a
- id_imm26  out  26  id_instr[25:0], to 26-bit extender a
- id_ext16_sel  out  1  16-bit extender sel (1 = sign, 0 = zero)
- id_ext26_sel  out  1  26-bit extender sel (always 0 = zero-extend jump target)
- id_byte_sel  out  1  8-bit load extender sel carried to MEM (1 = lb sign, 0 = lbu zero)
- id_imm_kind  out  2  0 = none (R-type/bubble), 1 = imm16, 2 = imm26, 3 = reserved (never driven)

Behaviour:
- Reset (async, active-high): id_valid = 0, id_instr = NOP_WORD, id_pc = 0. All decoded outputs are 0 while in reset. Release takes effect at the next rising edge.
- Update priority at each posedge: reset > flush > stall > load.
  - flush = 1: id_valid <= 0, id_instr <= NOP_WORD, id_pc <= 0. Flush wins over a simultaneous stall.
  - stall = 1 (flush = 0): all registers hold their values.
  - Otherwise: id_valid <= if_valid, id_pc <= if_pc. id_instr <= if_instr if if_valid, else NOP_WORD.
- Latency: one cycle, IF to ID.
- Decoded outputs are combinational from the registered id_instr, so they are valid in the same cycle as id_instr. When id_valid = 0, every decoded output is forced to 0.
- Decode uses op = id_instr[31:26]:
  - 0x08, 0x09, 0x0A, 0x0B, 0x04, 0x05, 0x20, 0x24, 0x23, 0x28, 0x2B: kind 1, ext16_sel 1 (sign).
  - 0x0C, 0x0D, 0x0E, 0x0F: kind 1, ext16_sel 0 (zero).
  - 0x02, 0x03: kind 2, ext26_sel 0.
  - 0x00 and any unlisted opcode: kind 0, all sels 0.
  - byte_sel = 1 only for op 0x20 (lb). For 0x24 (lbu) it is 0.
- id_imm16 and id_imm26 are pure bit slices and are never masked, except that they are 0 when id_valid = 0.
- Stall lasting N cycles: outputs are identical for all N cycles. The first new instruction appears on the cycle after stall deasserts.
- if_valid = 0 with no stall: a bubble enters, so id_valid = 0 next cycle.

Optional Feature:
- Macro IFID_STALL_CNT_EN.
- When defined, adds output stall_cycles (32 bits):
  - Reset to 0.
  - Increments on every posedge where stall = 1, flush = 0 and id_valid = 1.
  - Saturates at all-ones.
- When not defined, the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - Opcode localparams (OP_RTYPE, OP_ADDI … OP_SW, OP_J, OP_JAL).
  - IMM_NONE/IMM16/IMM26 kind encodings.
  - NOP_WORD constant.
- One natural sub-module: imm_decode. It is purely combinational, maps op and valid to kind/ext16_sel/ext26_sel/byte_sel, and is reused by the verification reference model.

Test Plan:
1. Reset, then load if_instr = 32'h2008FFFC (addi), if_valid = 1 → next cycle id_valid = 1, id_imm16 = 16'hFFFC, ext16_sel = 1, kind = 1.
2. Load 32'h3508_8000 (ori) → ext16_sel = 0, kind = 1, imm16 = 16'h8000. Then 32'h0810_0004 (j) → kind = 2, imm26 = 26'h010_0004, ext26_sel = 0.
3. Hold stall = 1 for 3 cycles while if_instr changes → id_instr/id_pc unchanged all 3 cycles, if_ready = 0. Deassert → new instruction appears on the next cycle.
4. Assert stall = 1 and flush = 1 together with a valid instruction held → next cycle id_valid = 0, id_instr = 0, kind = 0, all sels 0, if_ready = 1.
5. Load 32'h8109_0003 (lb) then 32'h9109_0003 (lbu) → byte_sel 1 then 0, ext16_sel = 1 for both.
6. Assert reset asynchronously mid-cycle while holding valid state → outputs go to reset values immediately, without waiting for a clock edge. With IFID_STALL_CNT_EN defined, run 5 valid stall cycles → stall_cycles = 5, and reset returns it to 0.
